// File: rtl/approx_adder_pkg.sv
// Shared definitions for the approximate-adder pipeline.
//   MODE_EXACT / MODE_LOA : values of the mode input
//   add_mode_e            : typed view of the mode bit
//   DEF_*                 : default parameter values for approx_adder_pipe
package approx_adder_pkg;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_LOA   = 1'b1;

  typedef enum logic {
    ADD_EXACT = MODE_EXACT,
    ADD_LOA   = MODE_LOA
  } add_mode_e;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_APPROX_BITS = 4;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/loa_lower.sv
// Lower-part adder of the approximate adder (purely combinational).
//   a_lo_i, b_lo_i : low K operand bits (width 1 when K=0, then ignored)
//   mode_i         : 0 = exact, 1 = lower-part OR
//   l_o            : lower result bits
//   ck_o           : carry into the upper part
module loa_lower
  import approx_adder_pkg::*;
#(
  parameter int unsigned K = DEF_APPROX_BITS,
  localparam int unsigned LW = (K > 0) ? K : 1
) (
  input  logic [LW-1:0] a_lo_i,
  input  logic [LW-1:0] b_lo_i,
  input  logic          mode_i,
  output logic [LW-1:0] l_o,
  output logic          ck_o
);

  if (K == 0) begin : g_none
    logic unused_in;
    assign unused_in = ^{a_lo_i, b_lo_i, mode_i};
    assign l_o       = '0;
    assign ck_o      = 1'b0;
  end else begin : g_lower
    logic [K:0] exact_sum;

    always_comb begin
      exact_sum = {1'b0, a_lo_i} + {1'b0, b_lo_i};
      l_o       = exact_sum[K-1:0];
      ck_o      = exact_sum[K];
      if (add_mode_e'(mode_i) == ADD_LOA) begin
        l_o  = a_lo_i | b_lo_i;
        // Carry guessed from the top lower bits only.
        ck_o = a_lo_i[K-1] & b_lo_i[K-1];
      end
    end
  end

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage pipelined lower-part-OR approximate adder with error counter.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, mode)
//   out_valid/out_ready : result handshake (sum, sum_err)
//   sum                 : WIDTH+1 bit result including carry-out
//   sum_err             : result differs from the exact a+b
//   err_clr / err_cnt   : clear / saturating count of delivered errors
module approx_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned APPROX_BITS = DEF_APPROX_BITS,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             sum_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned K  = APPROX_BITS;
  localparam int unsigned LW = (K > 0) ? K : 1;
  localparam int unsigned HW = (WIDTH > K) ? WIDTH - K : 1;

  logic             adv;

  logic [LW-1:0]    a_lo_d, b_lo_d, l_d;
  logic             ck_d;
  logic [HW-1:0]    a_hi_d, b_hi_d;
  logic [WIDTH:0]   exact_d;

  logic             s1_valid_q;
  logic             mode_q;
  logic [LW-1:0]    l_q;
  logic             ck_q;
  logic [HW-1:0]    a_hi_q, b_hi_q;
  logic [WIDTH:0]   exact_q;

  logic [WIDTH:0]   sum_d;
  logic             err_d;
  logic             out_valid_q;
  logic [WIDTH:0]   sum_q;
  logic             sum_err_q;
  logic [CNT_W-1:0] err_cnt_q;

  // Both stages move together; depends only on registered state and out_ready.
  assign adv      = !out_valid_q | out_ready;
  assign in_ready = adv;

  if (K == 0) begin : g_split_k0
    assign a_lo_d = '0;
    assign b_lo_d = '0;
    assign a_hi_d = a;
    assign b_hi_d = b;
  end else if (K == WIDTH) begin : g_split_kw
    assign a_lo_d = a;
    assign b_lo_d = b;
    assign a_hi_d = '0;
    assign b_hi_d = '0;
  end else begin : g_split
    assign a_lo_d = a[K-1:0];
    assign b_lo_d = b[K-1:0];
    assign a_hi_d = a[WIDTH-1:K];
    assign b_hi_d = b[WIDTH-1:K];
  end

  loa_lower #(.K(K)) u_lower (
    .a_lo_i (a_lo_d),
    .b_lo_i (b_lo_d),
    .mode_i (mode),
    .l_o    (l_d),
    .ck_o   (ck_d)
  );

  assign exact_d = {1'b0, a} + {1'b0, b};

  // Stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      mode_q     <= MODE_EXACT;
      l_q        <= '0;
      ck_q       <= 1'b0;
      a_hi_q     <= '0;
      b_hi_q     <= '0;
      exact_q    <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      mode_q     <= mode;
      l_q        <= l_d;
      ck_q       <= ck_d;
      a_hi_q     <= a_hi_d;
      b_hi_q     <= b_hi_d;
      exact_q    <= exact_d;
    end
  end

  if (K == 0) begin : g_join_k0
    logic unused_l;
    assign unused_l = ^l_q;
    assign sum_d    = {1'b0, a_hi_q} + {1'b0, b_hi_q} + {{WIDTH{1'b0}}, ck_q};
  end else if (K == WIDTH) begin : g_join_kw
    logic unused_hi;
    assign unused_hi = ^{a_hi_q, b_hi_q};
    assign sum_d     = {ck_q, l_q};
  end else begin : g_join
    logic [HW:0] hi_sum;
    assign hi_sum = {1'b0, a_hi_q} + {1'b0, b_hi_q} + {{HW{1'b0}}, ck_q};
    assign sum_d  = {hi_sum, l_q};
  end

  // Exact mode matches exact_q by construction; gating by mode_q keeps that explicit.
  assign err_d = (mode_q == MODE_LOA) && (sum_d != exact_q);

  // Stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      sum_err_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      sum_q       <= sum_d;
      sum_err_q   <= err_d;
    end
  end

  // Error counter: clear wins over a simultaneous increment
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt_q <= '0;
    end else if (out_valid_q && out_ready && sum_err_q && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign sum_err   = sum_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_approx_adder_pipe.sv
module tb_approx_adder_pipe;

  localparam int NDUT = 3;
  localparam int KV [NDUT] = '{4, 0, 8};

  logic       clk = 1'b0;
  logic       rst, in_valid, mode, out_ready, err_clr;
  logic [7:0] a, b;

  logic       in_rdy [NDUT];
  logic       o_vld  [NDUT];
  logic [8:0] s_sum  [NDUT];
  logic       s_err  [NDUT];
  logic [1:0] e_cnt  [NDUT];

  always #5 clk = ~clk;

  approx_adder_pipe #(.WIDTH(8), .APPROX_BITS(4), .CNT_W(2)) u_k4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .a(a), .b(b),
    .mode(mode), .out_valid(o_vld[0]), .out_ready(out_ready), .sum(s_sum[0]),
    .sum_err(s_err[0]), .err_clr(err_clr), .err_cnt(e_cnt[0]));

  approx_adder_pipe #(.WIDTH(8), .APPROX_BITS(0), .CNT_W(2)) u_k0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .a(a), .b(b),
    .mode(mode), .out_valid(o_vld[1]), .out_ready(out_ready), .sum(s_sum[1]),
    .sum_err(s_err[1]), .err_clr(err_clr), .err_cnt(e_cnt[1]));

  approx_adder_pipe #(.WIDTH(8), .APPROX_BITS(8), .CNT_W(2)) u_k8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]), .a(a), .b(b),
    .mode(mode), .out_valid(o_vld[2]), .out_ready(out_ready), .sum(s_sum[2]),
    .sum_err(s_err[2]), .err_clr(err_clr), .err_cnt(e_cnt[2]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
  } txn_t;

  txn_t        q[$];
  int unsigned cm [NDUT];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          in_x, out_x;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: arithmetic statement of the exact / lower-part-OR rules.
  function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y,
                                         input logic m, input int k);
    int unsigned mask, lo, hi, ck, xi, yi;
    xi = x;
    yi = y;
    if (!m || k == 0) return 9'(xi + yi);
    mask = (1 << k) - 1;
    lo   = (xi | yi) & mask;
    ck   = (xi >> (k - 1)) & (yi >> (k - 1)) & 1;
    hi   = (xi >> k) + (yi >> k) + ck;
    return 9'((hi << k) | lo);
  endfunction

  // One clock: drive inputs at the negedge, resolve handshakes, check, step the model.
  task automatic cycle(input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                       input bit im, input bit ordy, input bit clr);
    bit   ee [NDUT];
    txn_t t;
    logic [8:0] e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    mode      = im;
    out_ready = ordy;
    err_clr   = clr;
    #1;
    in_x  = iv && in_rdy[0];
    out_x = o_vld[0] && ordy;
    for (int d = 0; d < NDUT; d++) ee[d] = 1'b0;
    for (int d = 1; d < NDUT; d++)
      chk($sformatf("vld_agree[k=%0d]", KV[d]), o_vld[d], o_vld[0]);
    if (out_x && !rst) begin
      if (q.size() == 0) begin
        chk("spurious_out", o_vld[0], 1'b0);
      end else begin
        t = q.pop_front();
        for (int d = 0; d < NDUT; d++) begin
          e     = ref_sum(t.a, t.b, t.m, KV[d]);
          ee[d] = (e != ({1'b0, t.a} + {1'b0, t.b}));
          chk($sformatf("sum[k=%0d a=%0h b=%0h m=%0d]", KV[d], t.a, t.b, t.m), s_sum[d], e);
          chk($sformatf("err[k=%0d a=%0h b=%0h m=%0d]", KV[d], t.a, t.b, t.m), s_err[d], ee[d]);
        end
      end
    end
    if (in_x && !rst) begin
      t.a = ia;
      t.b = ib;
      t.m = im;
      q.push_back(t);
    end
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (rst || clr) cm[d] = 0;
      else if (out_x && ee[d] && cm[d] < 3) cm[d]++;
    end
    if (rst) q.delete();
    @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      chk($sformatf("err_cnt[k=%0d]", KV[d]), e_cnt[d], cm[d]);
  endtask

  task automatic directed(input logic [7:0] ia, input logic [7:0] ib, input bit im,
                          input logic [8:0] exp_sum, input bit exp_err, input int exp_cnt);
    cycle(1, ia, ib, im, 1, 0);
    chk("lat1_vld", o_vld[0], 1'b0);
    cycle(0, 8'h00, 8'h00, 0, 0, 0);
    chk("lat2_vld", o_vld[0], 1'b1);
    chk($sformatf("dir_sum %0h+%0h", ia, ib), s_sum[0], exp_sum);
    chk($sformatf("dir_err %0h+%0h", ia, ib), s_err[0], exp_err);
    cycle(0, 8'h00, 8'h00, 0, 1, 0);
    chk("dir_cnt", e_cnt[0], exp_cnt);
    chk("dir_drained", o_vld[0], 1'b0);
  endtask

  initial begin
    logic [7:0] pa [5];
    logic [7:0] pb [5];
    int sent, got;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    for (int d = 0; d < NDUT; d++) cm[d] = 0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_vld", o_vld[d], 1'b0);
      chk("rst_sum", s_sum[d], 9'h000);
      chk("rst_err", s_err[d], 1'b0);
      chk("rst_cnt", e_cnt[d], 2'd0);
    end
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_rdy[0], 1'b1);
    @(negedge clk);

    directed(8'hFF, 8'h01, 0, 9'h100, 0, 0);
    directed(8'h0F, 8'h01, 1, 9'h00F, 1, 1);
    directed(8'h08, 8'h08, 1, 9'h018, 1, 2);

    // Saturation, then clear on the same edge as an erroneous delivery.
    for (int i = 0; i < 5; i++) cycle(1, 8'h08, 8'h08, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 8'h00, 0, 1, 0);
    chk("sat_cnt", e_cnt[0], 2'd3);
    cycle(1, 8'h08, 8'h08, 1, 1, 0);
    cycle(0, 8'h00, 8'h00, 0, 1, 0);
    cycle(0, 8'h00, 8'h00, 0, 1, 1);
    chk("clr_prio_cnt", e_cnt[0], 2'd0);

    // Backpressure: four pairs, consumer stalled for the first three cycles.
    for (int i = 0; i < 5; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      cycle(sent < 4, pa[sent], pb[sent], 1, c >= 3, 0);
      if (in_x) sent++;
      if (out_x) got++;
      if (c == 2) chk("bp_in_ready_full", in_rdy[0], 1'b0);
    end
    chk("bp_sent", sent, 4);
    chk("bp_delivered", got, 4);

    // Random traffic.
    for (int c = 0; c < 400; c++)
      cycle(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
            ($urandom % 4) != 0, ($urandom % 32) == 0);
    for (int c = 0; c < 20 && q.size() != 0; c++) cycle(0, 8'h00, 8'h00, 0, 1, 0);
    chk("drain_empty", q.size(), 0);

    // Reset with both stages occupied and a nonzero counter.
    for (int i = 0; i < 3; i++) cycle(1, 8'h08, 8'h08, 1, 1, 0);
    cycle(1, 8'h0F, 8'h01, 1, 0, 0);
    cycle(1, 8'h08, 8'h08, 1, 0, 0);
    chk("pre_rst_vld", o_vld[0], 1'b1);
    rst = 1'b1;
    cycle(0, 8'h00, 8'h00, 0, 0, 0);
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      chk("midrst_vld", o_vld[d], 1'b0);
      chk("midrst_sum", s_sum[d], 9'h000);
      chk("midrst_cnt", e_cnt[d], 2'd0);
    end
    for (int c = 0; c < 6; c++) begin
      cycle(0, 8'h00, 8'h00, 0, 1, 0);
      chk("post_rst_vld", o_vld[0], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
